// File: rtl/mem_bist_initiator.sv
// mem_bist_initiator
// Initiator end of the valid/ready single-port memory interface. On a start
// pulse it writes a seed-derived pattern to every address, reads it all back
// and compares the data. It then repeats with the inverted pattern. The
// results are pass/fail, a saturating mismatch count, the first failing
// address and a handshake-timeout flag.
//
// Ports
//   clk_i, rst_i        clock (rising edge), async active-high reset
//   start_i, seed_i     start pulse (honoured in IDLE/DONE), pattern seed
//   addr_o, wdata_o,    request address, write data (0 on reads),
//   wr_rd_o, valid_o    1=write/0=read, request valid
//   ready_i, rdata_i    responder acknowledge and read data
//   busy_o, done_o,     run in progress, run finished (level),
//   pass_o, timeout_o   no mismatches and no timeout, aborted on timeout
//   err_cnt_o,          mismatch count (saturating),
//   first_err_addr_o    address of the first mismatch
module mem_bist_initiator #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      seed_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wdata_o,
  output logic                  wr_rd_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic [WIDTH-1:0]      rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [ADDR_WIDTH+1:0] err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [TW-1:0]         TMO_LAST  = TW'(TIMEOUT - 1);

  state_t                  state;
  logic [WIDTH-1:0]        seed_q;
  logic                    phase;
  logic [TW-1:0]           tcnt;

  logic                    progress;
  logic                    tmo;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic [WIDTH-1:0]        exp_cur;
  logic [WIDTH-1:0]        exp_next;
  logic [WIDTH-1:0]        exp_inv0;
  logic                    mismatch;

  function automatic logic [WIDTH-1:0] pattern(input logic [WIDTH-1:0]      s,
                                               input logic [ADDR_WIDTH-1:0] a,
                                               input logic                  p);
    logic [WIDTH-1:0] v;
    v = s + WIDTH'(a);
    return p ? ~v : v;
  endfunction

  // A REQ state advances on ready=1, a GAP state on ready=0. The wait
  // counter only runs while the current state is not advancing.
  always_comb begin
    progress  = 1'b0;
    case (state)
      WR_REQ, RD_REQ: progress = ready_i;
      WR_GAP, RD_GAP: progress = !ready_i;
      default:        progress = 1'b0;
    endcase
    tmo       = (tcnt == TMO_LAST);
    next_addr = addr_o + ADDR_WIDTH'(1);
    exp_cur   = pattern(seed_q, addr_o, phase);
    exp_next  = pattern(seed_q, next_addr, phase);
    exp_inv0  = pattern(seed_q, '0, 1'b1);
    mismatch  = (rdata_i != exp_cur);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      seed_q           <= '0;
      phase            <= 1'b0;
      tcnt             <= '0;
      addr_o           <= '0;
      wdata_o          <= '0;
      wr_rd_o          <= 1'b0;
      valid_o          <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      timeout_o        <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            seed_q           <= seed_i;
            phase            <= 1'b0;
            tcnt             <= '0;
            addr_o           <= '0;
            wdata_o          <= pattern(seed_i, '0, 1'b0);
            wr_rd_o          <= 1'b1;
            valid_o          <= 1'b1;
            busy_o           <= 1'b1;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            timeout_o        <= 1'b0;
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
            state            <= WR_REQ;
          end
        end
        default: begin
          if (!progress) begin
            if (tmo) begin
              valid_o   <= 1'b0;
              timeout_o <= 1'b1;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
              pass_o    <= 1'b0;
              tcnt      <= '0;
              state     <= DONE;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end else begin
            tcnt <= '0;
            case (state)
              WR_REQ: begin
                valid_o <= 1'b0;
                state   <= WR_GAP;
              end
              WR_GAP: begin
                valid_o <= 1'b1;
                if (addr_o != LAST_ADDR) begin
                  addr_o  <= next_addr;
                  wr_rd_o <= 1'b1;
                  wdata_o <= exp_next;
                  state   <= WR_REQ;
                end else begin
                  addr_o  <= '0;
                  wr_rd_o <= 1'b0;
                  wdata_o <= '0;
                  state   <= RD_REQ;
                end
              end
              RD_REQ: begin
                valid_o <= 1'b0;
                state   <= RD_GAP;
                if (mismatch) begin
                  if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + EW'(1);
                  // Count is still zero only before the first mismatch.
                  if (err_cnt_o == '0) first_err_addr_o <= addr_o;
                end
              end
              RD_GAP: begin
                if (addr_o != LAST_ADDR) begin
                  addr_o  <= next_addr;
                  valid_o <= 1'b1;
                  state   <= RD_REQ;
                end else if (!phase) begin
                  phase   <= 1'b1;
                  addr_o  <= '0;
                  wr_rd_o <= 1'b1;
                  wdata_o <= exp_inv0;
                  valid_o <= 1'b1;
                  state   <= WR_REQ;
                end else begin
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
                  pass_o <= (err_cnt_o == '0);
                  state  <= DONE;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
